ramfifo_drain: RTL
==================

RAMFIFO_DRAIN -- requirements
Module: ramfifo_drain

Interface
REQ-001 Parameter: WIDTH, default 32, data width of RAM read port and output.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clock.
REQ-004 enable  input  1  global advance; low freezes issue and output handshake.
REQ-005 fifo_empty  input  1  empty flag from FIFO control.
REQ-006 fifo_read  output  1  pop request to FIFO control, combinational.
REQ-007 ram_rdata  input  WIDTH  RAM read data, valid the cycle after a pop edge.
REQ-008 out_valid  output  1  buffered word available.
REQ-009 out_data  output  WIDTH  oldest buffered word.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 buf_count  output  2  words held in output buffer (0..2).

Function
REQ-012 Pop issue: fifo_read = enable & ~fifo_empty & ((buf_count + inflight - xfer) < 2), where xfer = enable & out_valid & out_ready.
REQ-013 inflight: 1-bit register; next value = issued pop of current cycle (fifo_read).
REQ-014 Return capture: when inflight=1, ram_rdata is written into the buffer at the clock edge, independent of enable.
REQ-015 Buffer: 2-entry FIFO; states EMPTY(0), ONE(1), TWO(2) = buf_count.
REQ-016 Transitions: capture only -> +1; xfer only -> -1; capture and xfer same cycle -> count unchanged, head advances, new word enters tail.
REQ-017 Capture into TWO without simultaneous xfer is impossible by REQ-012; no overflow path exists.
REQ-018 out_valid = (buf_count != 0); out_data = head entry; out_data stable while out_valid & ~xfer.
REQ-019 Latency: pop at edge N -> data captured at edge N+1 -> out_valid high after edge N+1 (2 cycles fifo_read to out_valid from empty buffer).
REQ-020 Throughput: with out_ready held high and FIFO non-empty, one word per cycle sustained.
REQ-021 fifo_empty rising with inflight=1: in-flight word still captured; no further pops.
REQ-022 enable low: fifo_read=0, xfer=0, buffer head unchanged; pending return still captured.
REQ-023 Words delivered in pop order; no duplication, no loss except by reset.

Reset
REQ-024 Reset: buf_count=0, inflight=0, out_valid=0, fifo_read=0 during reset cycle.
REQ-025 Reset mid-operation: in-flight return discarded; buffered words discarded; out_data value don't-care.
REQ-026 First pop possible in cycle after reset deasserts.

Configuration
REQ-027 Macro RAMFIFO_DRAIN_STATS_EN defined: adds output drain_count (16 bit), reset 0, +1 per xfer, wraps 0xFFFF -> 0x0000.
REQ-028 Macro undefined: no drain_count port, no counter logic; all other behaviour identical.

Structure
REQ-029 Shared package ramfifo_pkg: buffer-state enum (EMPTY/ONE/TWO), buffer depth constant 2, counter width constant 16.
REQ-030 One sub-module ramfifo_skid2: 2-entry storage, head/tail pointers, count; ramfifo_drain owns issue logic, inflight, stats.

Verification
REQ-031 Reset then fifo_empty=0, out_ready=1, enable=1, RAM returns 0xA0,0xA1,0xA2 -> out_data 0xA0,0xA1,0xA2 on consecutive cycles, first out_valid 2 cycles after first fifo_read.
REQ-032 out_ready=0, FIFO non-empty -> exactly 2 pops, buf_count=2, fifo_read=0 thereafter; out_ready=1 -> resumes 1 word/cycle in order.
REQ-033 enable=0 for 3 cycles mid-stream with inflight=1 -> word captured, buf_count +1, no fifo_read, out_data frozen; enable=1 -> order preserved.
REQ-034 fifo_empty asserts same cycle as pop -> single in-flight word delivered, no extra pop, buf_count returns to 0 after accept.
REQ-035 reset asserted with buf_count=2 and inflight=1 -> next cycle out_valid=0, buf_count=0; stale ram_rdata never appears on out_data.
REQ-036 RAMFIFO_DRAIN_STATS_EN defined, 65537 transfers -> drain_count=1.

Source files
------------

// File: rtl/ramfifo_pkg.sv
// Shared types and constants for the RAM-backed FIFO drain path.
// Buffer occupancy doubles as the skid buffer's state encoding.
package ramfifo_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/ramfifo_drain_if.sv
// Drain-side bundle: FIFO control pop/empty, RAM read data and the downstream valid/ready port.
// master = the drain engine, slave = FIFO control + RAM + downstream consumer.
interface ramfifo_drain_if #(
    parameter int WIDTH = 32
);

    logic             fifo_empty;
    logic             fifo_read;
    logic [WIDTH-1:0] ram_rdata;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       buf_count;

    modport master (
        input  fifo_empty,
        input  ram_rdata,
        input  out_ready,
        output fifo_read,
        output out_valid,
        output out_data,
        output buf_count
    );

    modport slave (
        output fifo_empty,
        output ram_rdata,
        output out_ready,
        input  fifo_read,
        input  out_valid,
        input  out_data,
        input  buf_count
    );

endinterface

// File: rtl/ramfifo_skid2.sv
// Two-entry output buffer: write at tail, read at head, occupancy kept as an EMPTY/ONE/TWO state.
// Head data is combinational from storage; the caller guarantees no write into TWO without a read.
module ramfifo_skid2
    import ramfifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output buf_state_t       state,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage is not reset; stale entries are never visible because state gates validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                EMPTY: begin
                    if (wr_en) begin
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (wr_en && !rd_en) begin
                        state <= TWO;
                    end else if (!wr_en && rd_en) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (rd_en && !wr_en) begin
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ramfifo_drain.sv
// Pops a RAM-backed FIFO into a 2-entry buffer; fifo_read to out_valid is 2 cycles, 1 word/cycle sustained.
// Pops are throttled so buffer + in-flight never exceeds 2; RAMFIFO_DRAIN_STATS_EN adds drain_count.
module ramfifo_drain
    import ramfifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    ramfifo_drain_if.master     bus
`ifdef RAMFIFO_DRAIN_STATS_EN
    ,
    output logic [CNT_W-1:0]    drain_count
`endif
);

    buf_state_t       state;
    logic [WIDTH-1:0] head_data;
    logic             inflight;
    logic             xfer;
    logic [2:0]       occ;

    assign xfer = enable & ~reset & (state != EMPTY) & bus.out_ready;

    // Occupancy after this cycle's accept; a new pop is only safe if its return has a slot.
    assign occ = {1'b0, state} + {2'b00, inflight} - {2'b00, xfer};

    assign bus.fifo_read = enable & ~reset & ~bus.fifo_empty & (occ < 3'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_read;
        end
    end

    // Capture of a returning word ignores enable: the RAM only holds it for one cycle.
    ramfifo_skid2 #(
        .WIDTH     (WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (inflight),
        .wr_data   (bus.ram_rdata),
        .rd_en     (xfer),
        .state     (state),
        .head_data (head_data)
    );

    assign bus.out_valid = ~reset & (state != EMPTY);
    assign bus.buf_count = reset ? 2'd0 : state;
    assign bus.out_data  = head_data;

`ifdef RAMFIFO_DRAIN_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            drain_count <= '0;
        end else if (xfer) begin
            drain_count <= drain_count + CNT_W'(1);
        end
    end
`endif

endmodule
